// File: rtl/sap1_pkg.sv
// Shared SAP-1 constants and the program-memory loader state encoding.
package sap1_pkg;

    // Address and word widths shared by the MAR, program counter and RAM.
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_e;

endpackage

// File: rtl/sap1_ram_array.sv
// 2**AW x DW register array: one synchronous write port, synchronous
// whole-array clear, asynchronous read.
module sap1_ram_array
    import sap1_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];

    // Clear-or-write storage update.
    // NOTE: every word is cleared on reset because the bus must read 0 after
    // reset; a cleared array cannot map onto a plain RAM macro, so it stays flops.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Zero-latency read: the addressed word is visible in the same cycle.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sap1_program_memory.sv
// SAP-1 16x8 program/data RAM. Run mode reads mem[address] onto the W bus
// when enable_out is low; program mode fills the array from address 0 over
// a valid/ready byte stream.
module sap1_program_memory
    import sap1_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              enable_out,
    output logic [DATA_W-1:0] to_BUS,
    output logic              bus_drive,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W:0]   prog_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    load_state_e         state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   ptr_d;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_d;
    logic                ready_q;
    logic                done_q;
    logic                write_en;
    logic [DATA_W-1:0]   rd_data;

    // A byte is accepted only while loading and while prog_mode is still high;
    // prog_mode falling wins over a simultaneous valid byte.
    assign write_en = ready_q && prog_valid && prog_mode;
    assign ptr_d    = ptr_q + ADDR_W'(1);
    assign count_d  = count_q + (ADDR_W + 1)'(1);

    sap1_ram_array #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_ram (
        .clock (clock),
        .clear (reset),
        .we    (write_en),
        .waddr (ptr_q),
        .wdata (prog_data),
        .raddr (address),
        .rdata (rd_data)
    );

    // Loader FSM with registered ready/done flags, pointer and word count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (!prog_mode) begin
            // Leaving program mode aborts any load; written words and the
            // count are kept until the next LOAD entry.
            state_q <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= LOAD;
                    ptr_q   <= '0;
                    count_q <= '0;
                    ready_q <= 1'b1;
                end
                LOAD: begin
                    if (write_en) begin
                        ptr_q   <= ptr_d;
                        count_q <= count_d;
                        if (ptr_q == LAST_ADDR) begin
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Array full; further bytes are ignored until prog_mode drops.
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_drive = !enable_out && !prog_mode && (state_q == IDLE);

    // Bus gating: drive the addressed word only when the bus is granted.
    // NOTE: the output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        to_BUS = '0;
        if (bus_drive) begin
            to_BUS = rd_data;
        end
    end

    assign prog_ready = ready_q;
    assign prog_done  = done_q;
    assign prog_count = count_q;

endmodule

// File: tb/tb_sap1_program_memory.sv
// Directed self-checking bench for sap1_program_memory.
module tb_sap1_program_memory;

    logic       clock;
    logic       reset;
    logic [3:0] address;
    logic       enable_out;
    logic [7:0] to_BUS;
    logic       bus_drive;
    logic       prog_mode;
    logic       prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready;
    logic       prog_done;
    logic [4:0] prog_count;

    int total;
    int bad;

    // Expected memory contents, written by the bench as it streams bytes.
    logic [7:0] exp_mem [16];

    sap1_program_memory dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .enable_out (enable_out),
        .to_BUS     (to_BUS),
        .bus_drive  (bus_drive),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .prog_count (prog_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Read all 16 words in run mode and compare against exp_mem.
    task automatic sweep_read(input string tag);
        enable_out = 1'b0;
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #1;
            total++;
            if (to_BUS !== exp_mem[a] || bus_drive !== 1'b1) begin
                $display("FAIL %s addr=%0d: to_BUS=%h bus_drive=%b expected %h/1",
                         tag, a, to_BUS, bus_drive, exp_mem[a]);
                bad++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; prog_mode = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
        enable_out = 1'b0; address = 4'h7;
        tick(); tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        total++;
        if (to_BUS !== 8'h00 || bus_drive !== 1'b1) begin
            $display("FAIL reset_bus: to_BUS=%h bus_drive=%b expected 00/1", to_BUS, bus_drive);
            bad++;
        end
        total++;
        if (prog_ready !== 1'b0 || prog_done !== 1'b0 || prog_count !== 5'd0) begin
            $display("FAIL reset_flags: ready=%b done=%b count=%0d expected 0/0/0",
                     prog_ready, prog_done, prog_count);
            bad++;
        end
    endtask

    task automatic test_full_load();
        prog_mode = 1'b1;
        tick();
        total++;
        if (prog_ready !== 1'b1 || bus_drive !== 1'b0) begin
            $display("FAIL load_entry: ready=%b bus_drive=%b expected 1/0", prog_ready, bus_drive);
            bad++;
        end
        prog_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prog_data  = 8'h10 + 8'(i);
            exp_mem[i] = 8'h10 + 8'(i);
            tick();
            if (i == 7 || i == 14) begin
                total++;
                if (prog_count !== 5'(i + 1) || prog_done !== 1'b0) begin
                    $display("FAIL load_count_%0d: count=%0d done=%b expected %0d/0",
                             i, prog_count, prog_done, i + 1);
                    bad++;
                end
            end
        end
        prog_valid = 1'b0;
        total++;
        if (prog_done !== 1'b1 || prog_ready !== 1'b0 || prog_count !== 5'd16) begin
            $display("FAIL load_done: done=%b ready=%b count=%0d expected 1/0/16",
                     prog_done, prog_ready, prog_count);
            bad++;
        end
        prog_mode = 1'b0;
        tick();
        enable_out = 1'b0; address = 4'hA;
        #1;
        total++;
        if (to_BUS !== 8'h1A || bus_drive !== 1'b1) begin
            $display("FAIL load_readback: to_BUS=%h bus_drive=%b expected 1a/1", to_BUS, bus_drive);
            bad++;
        end
        total++;
        if (prog_done !== 1'b0 || prog_count !== 5'd16) begin
            $display("FAIL load_exit: done=%b count=%0d expected 0/16", prog_done, prog_count);
            bad++;
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_cnt [4];
        exp_cnt[0] = 4'd1; exp_cnt[1] = 4'd1; exp_cnt[2] = 4'd2; exp_cnt[3] = 4'd2;
        prog_mode = 1'b1;
        tick();
        total++;
        if (prog_count !== 5'd0) begin
            $display("FAIL bp_count_clear: count=%0d expected 0", prog_count);
            bad++;
        end
        for (int i = 0; i < 4; i++) begin
            prog_valid = (i % 2 == 0);
            prog_data  = 8'hB0 + 8'(i);
            tick();
            total++;
            if (prog_count !== {1'b0, exp_cnt[i]}) begin
                $display("FAIL bp_gap_%0d: count=%0d expected %0d", i, prog_count, exp_cnt[i]);
                bad++;
            end
        end
        exp_mem[0] = 8'hB0;
        exp_mem[1] = 8'hB2;
        prog_valid = 1'b1;
        for (int k = 2; k < 16; k++) begin
            prog_data  = 8'hC0 + 8'(k);
            exp_mem[k] = 8'hC0 + 8'(k);
            tick();
        end
        // Extra bytes in DONE must not write or count.
        prog_data = 8'hFF;
        tick(); tick();
        prog_valid = 1'b0;
        total++;
        if (prog_done !== 1'b1 || prog_count !== 5'd16 || prog_ready !== 1'b0) begin
            $display("FAIL bp_done_ignore: done=%b count=%0d ready=%b expected 1/16/0",
                     prog_done, prog_count, prog_ready);
            bad++;
        end
        prog_mode = 1'b0;
        tick();
        sweep_read("bp_mem");
    endtask

    task automatic test_abort();
        prog_mode = 1'b1;
        tick();
        prog_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            prog_data  = 8'hA0 + 8'(i);
            exp_mem[i] = 8'hA0 + 8'(i);
            tick();
        end
        // prog_mode falls with a valid byte present: that byte must not land.
        prog_mode = 1'b0;
        prog_data = 8'hEE;
        tick();
        prog_valid = 1'b0;
        total++;
        if (prog_ready !== 1'b0 || prog_done !== 1'b0 || prog_count !== 5'd5) begin
            $display("FAIL abort_state: ready=%b done=%b count=%0d expected 0/0/5",
                     prog_ready, prog_done, prog_count);
            bad++;
        end
        sweep_read("abort_mem");
    endtask

    task automatic test_bus_gating();
        enable_out = 1'b1; address = 4'h3;
        #1;
        total++;
        if (to_BUS !== 8'h00 || bus_drive !== 1'b0) begin
            $display("FAIL gate_disabled: to_BUS=%h bus_drive=%b expected 00/0", to_BUS, bus_drive);
            bad++;
        end
        enable_out = 1'b0; prog_mode = 1'b1;
        #1;
        total++;
        if (to_BUS !== 8'h00 || bus_drive !== 1'b0) begin
            $display("FAIL gate_prog_comb: to_BUS=%h bus_drive=%b expected 00/0", to_BUS, bus_drive);
            bad++;
        end
        tick();
        total++;
        if (to_BUS !== 8'h00 || bus_drive !== 1'b0) begin
            $display("FAIL gate_prog_load: to_BUS=%h bus_drive=%b expected 00/0", to_BUS, bus_drive);
            bad++;
        end
        prog_mode = 1'b0;
        tick();
        sweep_read("gate_sweep");
    endtask

    task automatic test_reset_mid_load();
        prog_mode = 1'b1;
        tick();
        prog_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prog_data = 8'h55 + 8'(i);
            tick();
        end
        reset = 1'b1;
        prog_data = 8'h77;
        tick();
        total++;
        if (prog_ready !== 1'b0 || prog_count !== 5'd0 || prog_done !== 1'b0) begin
            $display("FAIL midreset_flags: ready=%b count=%0d done=%b expected 0/0/0",
                     prog_ready, prog_count, prog_done);
            bad++;
        end
        reset = 1'b0; prog_mode = 1'b0; prog_valid = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        sweep_read("midreset_mem");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_full_load();
        test_backpressure();
        test_abort();
        test_bus_gating();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
